// File: rtl/soc_bus_fabric.sv
// -----------------------------------------------------------------------------
// soc_bus_fabric
//
// CPU-to-peripheral bus fabric for the picorv32 native memory interface.
// The top nibble of the CPU address selects one of up to 16 regions. A request
// to a populated region is forwarded to that slave over a registered
// valid/ready handshake. A request to an unpopulated region, or to a slave
// that holds off ready for too long, completes with an error response. That
// response returns ERR_RDATA and is recorded in a sticky error flag together
// with the faulting address.
//
// Ports
//   i_clk, i_rst      system clock; asynchronous active-high reset
//   i_cpu_valid       CPU request valid
//   i_cpu_addr        CPU byte address ([31:28] selects the region)
//   i_cpu_wdata       CPU write data
//   i_cpu_wstrb       byte write strobes; 0 means read
//   o_cpu_ready       one-cycle completion pulse
//   o_cpu_rdata       read data, valid while o_cpu_ready is high
//   o_slv_valid       one-hot request to the addressed slave
//   o_slv_addr        latched address, shared by all slaves
//   o_slv_wdata       latched write data, shared by all slaves
//   o_slv_wstrb       latched write strobes, shared by all slaves
//   i_slv_ready       per-slave completion
//   i_slv_rdata       per-slave read data; slave k uses bits [32k+31:32k]
//   o_err             sticky bus-error flag
//   o_err_addr        address of the first error since the last clear
//   i_err_clr         clears o_err (a simultaneous new error wins)
// -----------------------------------------------------------------------------
module soc_bus_fabric #(
    parameter int          NUM_SLAVES = 8,
    parameter logic [15:0] SLAVE_EN   = 16'h003F,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cpu_valid,
    input  logic [31:0]              i_cpu_addr,
    input  logic [31:0]              i_cpu_wdata,
    input  logic [3:0]               i_cpu_wstrb,
    output logic                     o_cpu_ready,
    output logic [31:0]              o_cpu_rdata,
    output logic [NUM_SLAVES-1:0]    o_slv_valid,
    output logic [31:0]              o_slv_addr,
    output logic [31:0]              o_slv_wdata,
    output logic [3:0]               o_slv_wstrb,
    input  logic [NUM_SLAVES-1:0]    i_slv_ready,
    input  logic [32*NUM_SLAVES-1:0] i_slv_rdata,
    output logic                     o_err,
    output logic [31:0]              o_err_addr,
    input  logic                     i_err_clr
);

    // The counter only has to reach TIMEOUT. It keeps one bit when the
    // timeout is disabled so that the declarations stay legal.
    localparam int              CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              region_q, region_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   slv_valid_q, slv_valid_d;
    logic [31:0]             slv_addr_q, slv_addr_d;
    logic [31:0]             slv_wdata_q, slv_wdata_d;
    logic [3:0]              slv_wstrb_q, slv_wstrb_d;
    logic                    cpu_ready_q, cpu_ready_d;
    logic [31:0]             cpu_rdata_q, cpu_rdata_d;
    logic                    err_q, err_d;
    logic [31:0]             err_addr_q, err_addr_d;

    logic [15:0]             pop_mask;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic                    timeout_hit;
    logic                    err_set;

    // A region counts as populated only if its enable bit is set and it also
    // lies inside the range of instantiated slave ports.
    always_comb begin
        pop_mask = '0;
        for (int k = 0; k < 16; k++) begin
            pop_mask[k] = SLAVE_EN[k] && (k < NUM_SLAVES);
        end
    end

    // Pick the ready and read data of the latched region. Ready bits from every
    // other slave are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (region_q == 4'(k)) begin
                sel_ready = i_slv_ready[k];
                sel_rdata = i_slv_rdata[32*k +: 32];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_CNT);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so that no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        region_d    = region_q;
        cnt_d       = cnt_q;
        slv_valid_d = slv_valid_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        slv_wstrb_d = slv_wstrb_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        err_set     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_cpu_valid) begin
                    slv_addr_d  = i_cpu_addr;
                    slv_wdata_d = i_cpu_wdata;
                    slv_wstrb_d = i_cpu_wstrb;
                    region_d    = i_cpu_addr[31:28];
                    cnt_d       = '0;
                    if (pop_mask[i_cpu_addr[31:28]]) begin
                        state_d = ST_ACCESS;
                        for (int k = 0; k < NUM_SLAVES; k++) begin
                            slv_valid_d[k] = (i_cpu_addr[31:28] == 4'(k));
                        end
                    end else begin
                        // Nothing is behind this region. Answer straight away,
                        // and any write is simply dropped.
                        state_d     = ST_RESP;
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = ERR_RDATA;
                        err_set     = 1'b1;
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Ready is checked before the timeout, so a slave that answers
                // on the final allowed cycle still gets a normal response.
                if (sel_ready) begin
                    state_d     = ST_RESP;
                    slv_valid_d = '0;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = sel_rdata;
                end else if (timeout_hit) begin
                    state_d     = ST_RESP;
                    slv_valid_d = '0;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = ERR_RDATA;
                    err_set     = 1'b1;
                end
            end

            ST_RESP: begin
                // Always go back through IDLE. If the CPU keeps valid high
                // during its ready cycle, this stops it from seeing a second
                // ready pulse.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new error sets the flag even when a clear arrives in the same cycle.
    // The address is captured only for the first error since the last clear.
    always_comb begin
        err_d      = err_set | (err_q & ~i_err_clr);
        err_addr_d = (err_set && !err_q) ? slv_addr_d : err_addr_q;
    end

    // NOTE: state registers use non-blocking assignments only. Every flop then
    // samples the pre-edge value of every other flop, whatever the block order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            region_q    <= '0;
            cnt_q       <= '0;
            slv_valid_q <= '0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            slv_wstrb_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            cnt_q       <= cnt_d;
            slv_valid_q <= slv_valid_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            slv_wstrb_q <= slv_wstrb_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign o_cpu_ready = cpu_ready_q;
    assign o_cpu_rdata = cpu_rdata_q;
    assign o_slv_valid = slv_valid_q;
    assign o_slv_addr  = slv_addr_q;
    assign o_slv_wdata = slv_wdata_q;
    assign o_slv_wstrb = slv_wstrb_q;
    assign o_err       = err_q;
    assign o_err_addr  = err_addr_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// -----------------------------------------------------------------------------
// tb_soc_bus_fabric
//
// Self-checking bench for soc_bus_fabric. It is built with TIMEOUT=4 so that
// timeouts happen in a few cycles. Behavioural slaves answer after a chosen
// number of wait cycles. The expected latency, read data and error state are
// worked out from the fabric's rules.
// -----------------------------------------------------------------------------
module tb_soc_bus_fabric;

    localparam int          NS   = 8;
    localparam int          TO   = 4;
    localparam logic [15:0] SEN  = 16'h003F;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_valid;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wstrb;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic [NS-1:0]     slv_valid;
    logic [31:0]       slv_addr;
    logic [31:0]       slv_wdata;
    logic [3:0]        slv_wstrb;
    logic [NS-1:0]     slv_ready;
    logic [32*NS-1:0]  slv_rdata;
    logic              err;
    logic [31:0]       err_addr;
    logic              err_clr;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_err;
    logic [31:0] m_err_addr;

    always #5 clk = ~clk;

    soc_bus_fabric #(
        .NUM_SLAVES (NS),
        .SLAVE_EN   (SEN),
        .TIMEOUT    (TO),
        .ERR_RDATA  (ERRD)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_valid (cpu_valid),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .i_cpu_wstrb (cpu_wstrb),
        .o_cpu_ready (cpu_ready),
        .o_cpu_rdata (cpu_rdata),
        .o_slv_valid (slv_valid),
        .o_slv_addr  (slv_addr),
        .o_slv_wdata (slv_wdata),
        .o_slv_wstrb (slv_wstrb),
        .i_slv_ready (slv_ready),
        .i_slv_rdata (slv_rdata),
        .o_err       (err),
        .o_err_addr  (err_addr),
        .i_err_clr   (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
        check({pfx, "_cpu_rdata"}, cpu_rdata, 32'd0);
        check({pfx, "_slv_valid"}, 32'(slv_valid), 32'd0);
        check({pfx, "_slv_addr"}, slv_addr, 32'd0);
        check({pfx, "_slv_wdata"}, slv_wdata, 32'd0);
        check({pfx, "_slv_wstrb"}, 32'(slv_wstrb), 32'd0);
        check({pfx, "_err"}, 32'(err), 32'd0);
        check({pfx, "_err_addr"}, err_addr, 32'd0);
    endtask

    function automatic bit populated(input logic [31:0] a);
        int r;
        r = int'(a[31:28]);
        return (r < NS) && SEN[r];
    endfunction

    // One CPU transaction. The addressed slave answers after wait_n wait
    // cycles and returns rv. clr pulses i_err_clr on the edge where the
    // response is produced. The CPU holds valid through its ready cycle, as
    // picorv32 does.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int wait_n,
                           input bit clr, input logic [31:0] rv);
        bit          pop;
        bit          exp_err;
        int          exp_lat;
        int          exp_vcyc;
        logic [NS-1:0] exp_oh;
        logic [31:0] exp_rd;
        logic [2:0]  ri;
        int          lat;
        int          vcyc;
        int          seen;
        logic [31:0] got_rd;

        pop      = populated(addr);
        ri       = addr[30:28];
        exp_err  = !pop || (wait_n > TO);
        exp_lat  = !pop ? 1 : ((wait_n > TO) ? TO + 2 : wait_n + 2);
        exp_vcyc = !pop ? 0 : (((wait_n > TO) ? TO : wait_n) + 1);
        exp_oh   = pop ? (NS'(1) << ri) : '0;
        exp_rd   = exp_err ? ERRD : rv;
        lat      = 0;
        vcyc     = 0;
        seen     = 0;
        got_rd   = '0;

        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        err_clr   = clr && (exp_lat == 1);

        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            err_clr   = 1'b0;
            slv_ready = '0;
            for (int j = 0; j < NS; j++) slv_rdata[32*j +: 32] = $urandom;
            if (slv_valid != '0) begin
                vcyc++;
                check("slv_valid", 32'(slv_valid), 32'(exp_oh));
                check("slv_addr", slv_addr, addr);
                check("slv_wdata", slv_wdata, wdata);
                check("slv_wstrb", 32'(slv_wstrb), 32'(wstrb));
            end
            if (cpu_ready) begin
                lat    = e;
                got_rd = cpu_rdata;
                break;
            end
            if (pop && slv_valid[ri]) begin
                if (seen == wait_n) begin
                    slv_ready[ri]            = 1'b1;
                    slv_rdata[32*ri +: 32]   = rv;
                end
                seen++;
            end
            if (clr && (e == exp_lat - 1)) err_clr = 1'b1;
        end

        check("latency", 32'(lat), 32'(exp_lat));
        check("rdata", got_rd, exp_rd);
        check("slv_valid_cycles", 32'(vcyc), 32'(exp_vcyc));

        // Valid was still high during the ready cycle. There must be no second
        // ready pulse and no new slave request.
        @(negedge clk);
        check("single_ready", 32'(cpu_ready), 32'd0);
        check("no_reaccept", 32'(slv_valid), 32'd0);
        cpu_valid = 1'b0;
        cpu_wstrb = '0;

        if (exp_err) begin
            if (!m_err) m_err_addr = addr;
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
        end
        check("err", 32'(err), 32'(m_err));
        check("err_addr", err_addr, m_err_addr);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
        check("err_after_clr", 32'(err), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;

        rst       = 1'b1;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
        slv_ready = '0;
        slv_rdata = '0;
        err_clr   = 1'b0;
        m_err      = 1'b0;
        m_err_addr = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait read of region 0.
        run_txn(32'h0000_0000, 32'h0, 4'h0, 0, 1'b0, 32'h1234_5678);
        // Write with 3 wait cycles.
        run_txn(32'h3000_0004, 32'hCAFE_0001, 4'hF, 3, 1'b0, 32'h0);
        // Unpopulated region.
        run_txn(32'h7000_0000, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        // Timeout on slave 2, a second error that keeps the address, then an
        // error that coincides with a clear.
        pulse_clr();
        run_txn(32'h2000_0000, 32'h0, 4'h0, 20, 1'b0, 32'h0);
        run_txn(32'h6000_0000, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        run_txn(32'h6000_0010, 32'h0, 4'h0, 0, 1'b1, 32'h0);
        // Ready on the same cycle as the timeout: ready must win.
        run_txn(32'h1000_0008, 32'h0, 4'h0, TO, 1'b0, 32'hA5A5_0F0F);

        // Reset asserted in the middle of an ACCESS.
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = 32'h1000_0000;
        @(negedge clk);
        check("pre_rst_valid", 32'(slv_valid), 32'h2);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        cpu_valid = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        m_err      = 1'b0;
        m_err_addr = '0;
        run_txn(32'h1000_0040, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D);

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            a = {4'($urandom_range(0, 15)), 28'($urandom)};
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            run_txn(a, $urandom, s, $urandom_range(0, 6), ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/soc_bus_fabric.md
# soc_bus_fabric

Parametrised CPU-to-peripheral bus fabric for the picorv32 native memory interface, replacing the hand-written region decode and ready logic in the SoC top level. It decodes `i_cpu_addr[31:28]` into up to 16 slave regions, runs one registered valid/ready handshake per slave, and returns read data to the CPU. It also handles unpopulated regions and hung slaves with a bus-error response and sticky error capture. It sits between `picorv32` and the ROM, RAM, USB register, port and external-bus slaves.

## Interface
Parameters:
- `NUM_SLAVES`, 8 — number of decoded regions (1..16); region k matches `i_cpu_addr[31:28] == k`.
- `SLAVE_EN`, 16'h003F — bitmask of populated regions; bit k=0, or k >= NUM_SLAVES, makes region k unpopulated.
- `TIMEOUT`, 255 — maximum cycles a slave may hold off ready; 0 disables the timeout.
- `ERR_RDATA`, 32'hDEAD_BEEF — read data returned on any error response.

Ports:
- `i_clk` in 1 — system clock.
- `i_rst` in 1 — reset; asynchronous, active-high.
- `i_cpu_valid` in 1 — CPU request valid.
- `i_cpu_addr` in 32 — CPU byte address.
- `i_cpu_wdata` in 32 — CPU write data.
- `i_cpu_wstrb` in 4 — byte write strobes; 0 means read.
- `o_cpu_ready` out 1 — one-cycle completion pulse.
- `o_cpu_rdata` out 32 — read data; valid while `o_cpu_ready`=1.
- `o_slv_valid` out NUM_SLAVES — one-hot slave request.
- `o_slv_addr` out 32 — latched address, shared by all slaves.
- `o_slv_wdata` out 32 — latched write data, shared.
- `o_slv_wstrb` out 4 — latched strobes, shared.
- `i_slv_ready` in NUM_SLAVES — per-slave completion.
- `i_slv_rdata` in 32*NUM_SLAVES — per-slave read data; slave k occupies bits [32k+31:32k].
- `o_err` out 1 — sticky bus-error flag.
- `o_err_addr` out 32 — address of the first error since the last clear.
- `i_err_clr` in 1 — clears `o_err`.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE, `i_cpu_valid`=1:
  - Latch addr, wdata, wstrb and the region index.
  - Populated region → ACCESS.
  - Unpopulated region → RESP with error.
- ACCESS:
  - `o_slv_valid[region]`=1; all other bits 0.
  - Timeout counter increments every cycle. Width is `$clog2(TIMEOUT+1)`, minimum 1. The counter saturates and never wraps.
  - `i_slv_ready[region]`=1 → register that slave's rdata, go to RESP (normal). Ready bits of other slaves are ignored.
  - Counter == TIMEOUT and no ready (TIMEOUT≠0) → go to RESP with error. `o_slv_valid` drops on the same edge.
  - Ready and timeout in the same cycle: ready wins, so the response is normal.
- RESP:
  - `o_cpu_ready`=1 for exactly one cycle.
  - `o_cpu_rdata` = registered slave data, or `ERR_RDATA` on error.
  - Next state is IDLE. A new request can be accepted on the following cycle. There is no back-to-back acceptance from RESP, which prevents a double-ready on a held `i_cpu_valid`.
- Writes to a faulting region are dropped, but the CPU still receives ready.
- `i_cpu_valid` deasserting mid-transaction is ignored; the transaction completes.
- Error capture:
  - On each error response, `o_err` is set.
  - `o_err_addr` loads the latched address only if `o_err` was 0.
  - `i_err_clr` clears `o_err`. If set and clear occur in the same cycle, set wins and `o_err_addr` is not reloaded.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - `o_cpu_ready`=0, `o_cpu_rdata`=0, `o_slv_valid`=0.
  - `o_slv_addr`/`o_slv_wdata`/`o_slv_wstrb`=0.
  - `o_err`=0, `o_err_addr`=0, counter=0.
- Every output is registered.
- Latency, counting `i_cpu_valid` sampled at edge 0:
  - `o_slv_valid` is high from edge 1.
  - A zero-wait slave (ready at edge 1) gives `o_cpu_ready` at edge 2.
  - N wait cycles give `o_cpu_ready` at edge 2+N.
  - Unpopulated region gives `o_cpu_ready` at edge 1.
  - Timeout gives `o_cpu_ready` at edge TIMEOUT+2.
- Slave rule: `i_slv_ready` may be combinational or registered, but must be high only while its `o_slv_valid` is high. `o_slv_*` is stable for the whole ACCESS period.
- Reset asserted mid-ACCESS aborts the transaction immediately: `o_slv_valid` → 0 and no ready is issued.

## Test plan
- Read region 0 with a zero-wait slave returning 32'h1234_5678 → `o_slv_valid`=8'h01 for 1 cycle; `o_cpu_ready` at edge 2 with rdata 32'h1234_5678; `o_err`=0.
- Write 32'hCAFE_0001, wstrb 4'hF, to 0x3000_0004 with 3 wait cycles → `o_slv_valid[3]` high 4 cycles; `o_slv_addr`=0x3000_0004; `o_cpu_ready` at edge 5; exactly one ready pulse with `i_cpu_valid` held.
- Read 0x7000_0000 (bit 7 clear in SLAVE_EN) → `o_cpu_ready` at edge 1; rdata 32'hDEAD_BEEF; `o_err`=1; `o_err_addr`=0x7000_0000; no `o_slv_valid`.
- With TIMEOUT=4, slave 2 never ready → `o_cpu_ready` at edge 6 with 32'hDEAD_BEEF; a second error at 0x6000_0000 leaves `o_err_addr`=0x2000_0000; a third error coinciding with `i_err_clr` leaves `o_err`=1.
- Assert `i_rst` mid-ACCESS → all outputs 0 asynchronously; after release, a read of region 1 completes normally.
- Slave ready and timeout on the same cycle (TIMEOUT=2, ready at edge 3) → normal rdata; `o_err` unchanged.
